sbox_share_arbiter: RTL and testbench
=====================================

SBOX_SHARE_ARBITER -- requirements
Module: sbox_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter SHARES, default 4: masking shares, i.e. security order + 1.
REQ-003 SHALL have parameter LATENCY, default 8: masked S-box cycles from input to valid output.
REQ-004 SHALL have parameter FRESH_W, default 126: fresh-randomness bits per S-box evaluation.
REQ-005 SHALL have the following ports:
  clk  in  1  system clock.
  rst  in  1  asynchronous, active-low reset.
  req_valid  in  N_REQ  per-requester request.
  req_ready  out  N_REQ  per-requester accept, one-hot or zero.
  req_data  in  N_REQ*SHARES*4  shared 4-bit operands; requester i occupies slice i.
  rnd_valid  in  1  PRNG word available.
  rnd_ready  out  1  PRNG word consumed.
  rnd_data  in  FRESH_W  fresh randomness.
  sbox_in  out  SHARES*4  operand to the masked S-box.
  sbox_fresh  out  FRESH_W  randomness to the masked S-box.
  sbox_out  in  SHARES*4  masked S-box result.
  rsp_valid  out  N_REQ  one-hot result valid.
  rsp_ready  in  1  response consumer ready.
  rsp_data  out  SHARES*4  masked result.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY and RESP, with at most one operation in flight.
REQ-007 In IDLE, if any req_valid is high and rnd_valid is high, it SHALL grant exactly one requester by round-robin, starting at the index after the last grant.
REQ-008 On grant in cycle t, it SHALL pulse req_ready[g] and rnd_ready for one cycle, latch req_data slice g and rnd_data, and enter BUSY.
REQ-009 In IDLE with rnd_valid low, it SHALL keep req_ready and rnd_ready low, whatever the requests.
REQ-010 In BUSY, sbox_in and sbox_fresh SHALL hold the latched values, bit-stable, for LATENCY cycles (t+1..t+LATENCY); a down-counter counts LATENCY-1..0.
REQ-011 When the counter reaches 0, it SHALL register sbox_out into rsp_data, enter RESP, and assert rsp_valid[g] from cycle t+LATENCY+1.
REQ-012 In RESP, rsp_valid[g] and rsp_data SHALL hold until rsp_ready is high; on that edge it returns to IDLE.
REQ-013 The round-robin pointer SHALL update only on grant; simultaneous requests from all N_REQ SHALL be served in index order across successive operations.
REQ-014 Requests arriving during BUSY or RESP SHALL see req_ready low and be left pending; no request is dropped.
REQ-015 If rsp_ready is already high on entry to RESP, rsp_valid SHALL last exactly one cycle.
REQ-016 Shares SHALL never be combined: no logic XORs across share slices.

Reset
REQ-017 While rst is low, the FSM SHALL be IDLE, the pointer 0, and the counter 0.
REQ-018 While rst is low, req_ready, rnd_ready, rsp_valid, sbox_in, sbox_fresh and rsp_data SHALL all be 0.
REQ-019 A reset during BUSY or RESP SHALL abort the operation with no response emitted; after release, the first grant starts from index 0.

Configuration
REQ-020 With SBOX_ARB_IDLE_ZERO_EN defined, sbox_in and sbox_fresh SHALL be driven to 0 in IDLE and RESP.
REQ-021 Without SBOX_ARB_IDLE_ZERO_EN, sbox_in and sbox_fresh SHALL retain the last operation's values outside BUSY.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the default LATENCY and FRESH_W constants, and the share-slice width constant (4).
REQ-023 The round-robin grant logic SHALL be a sub-module, rr_grant: a one-hot grant from a request vector and a pointer.

Verification
REQ-024 Single request: req_valid=0001, rnd_valid=1, request shares of input 0x6 → req_ready[0] pulses at t, rsp_valid=0001 at t+9, and the XOR of the rsp_data shares equals S(0x6).
REQ-025 Contention: req_valid=1111 held → grants in order 0,1,2,3,0, with one operation every 10 cycles when rsp_ready=1.
REQ-026 Randomness starvation: rnd_valid=0 with req_valid=0010 → no grant; rnd_valid rises at cycle 20 → grant in cycle 20.
REQ-027 Backpressure: rsp_ready=0 for 5 cycles after RESP entry → rsp_valid and rsp_data stable for 5 cycles; the next grant happens only after the rsp_ready handshake.
REQ-028 Reset mid-BUSY: rst low at t+4 → all outputs 0, no rsp_valid; after release with req_valid=0100, requester 2 is granted.
REQ-029 Macro check: with SBOX_ARB_IDLE_ZERO_EN, sbox_in is 0 in IDLE; without it, sbox_in equals the previous operand.

Source files
------------

// File: rtl/sbox_share_arbiter_pkg.sv
// Shared types and constants for the masked S-box share arbiter.
package sbox_share_arbiter_pkg;

    localparam int unsigned SHARE_W     = 4;
    localparam int unsigned LATENCY_DEF = 8;
    localparam int unsigned FRESH_W_DEF = 126;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sbox_share_arbiter_rr_grant.sv
// Round-robin picker: one-hot grant of the first requester at or after the pointer.
module rr_grant #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_dist;
    int w_best;

    // Winner is the requester with the smallest cyclic distance from the pointer.
    always_comb begin
        o_idx  = '0;
        w_dist = 0;
        w_best = int'(N_REQ);
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + int'(N_REQ) - int'(i_ptr));
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_W'(i);
            end
        end
        o_any = |i_req;
        o_gnt = o_any ? (N_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin arbiter sharing one masked S-box among N_REQ requesters, one operation in flight.
// Optional feature: define SBOX_ARB_IDLE_ZERO_EN to drive sbox_in/sbox_fresh to 0 outside BUSY.
module sbox_share_arbiter
    import sbox_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned SHARES  = 4,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned FRESH_W = FRESH_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*SHARES*SHARE_W-1:0]   req_data,
    input  logic                              rnd_valid,
    output logic                              rnd_ready,
    input  logic [FRESH_W-1:0]                rnd_data,
    output logic [SHARES*SHARE_W-1:0]         sbox_in,
    output logic [FRESH_W-1:0]                sbox_fresh,
    input  logic [SHARES*SHARE_W-1:0]         sbox_out,
    output logic [N_REQ-1:0]                  rsp_valid,
    input  logic                              rsp_ready,
    output logic [SHARES*SHARE_W-1:0]         rsp_data
);

    localparam int unsigned OP_W  = SHARES * SHARE_W;
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_sbox_in;
    logic [FRESH_W-1:0] r_sbox_fresh;
    logic [OP_W-1:0]    r_rsp_data;
    logic [N_REQ-1:0]   r_rsp_valid;

    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_take;
    logic [OP_W-1:0]    w_op;

    rr_grant #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    // Same-cycle handshake: a request is accepted in the cycle randomness is available.
    assign w_take    = rst && (r_state == ST_IDLE) && rnd_valid && w_any;
    assign req_ready = w_take ? w_gnt : '0;
    assign rnd_ready = w_take;

    assign sbox_in    = r_sbox_in;
    assign sbox_fresh = r_sbox_fresh;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;

    // Whole-slice select of the granted operand; shares are moved, never mixed.
    always_comb begin
        w_op = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gidx == IDX_W'(i)) begin
                w_op = req_data[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_cnt        <= '0;
            r_sbox_in    <= '0;
            r_sbox_fresh <= '0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_sbox_in    <= w_op;
                        r_sbox_fresh <= rnd_data;
                        r_gidx       <= w_gidx;
                        r_ptr        <= (w_gidx == IDX_W'(N_REQ - 1)) ? '0 : (w_gidx + 1'b1);
                        r_cnt        <= CNT_W'(LATENCY - 1);
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= sbox_out;
                        r_rsp_valid <= N_REQ'(1) << r_gidx;
                        r_state     <= ST_RESP;
`ifdef SBOX_ARB_IDLE_ZERO_EN
                        r_sbox_in    <= '0;
                        r_sbox_fresh <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Self-checking bench for sbox_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level model; the masked S-box is modelled as a delayed PRESENT S-box.
module tb_sbox_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 8;
    localparam int FW  = 126;
    localparam int OPW = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*OPW-1:0]   req_data;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [FW-1:0]      rnd_data;
    logic [OPW-1:0]     sbox_in;
    logic [FW-1:0]      sbox_fresh;
    logic [OPW-1:0]     sbox_out;
    logic [N-1:0]       rsp_valid;
    logic               rsp_ready;
    logic [OPW-1:0]     rsp_data;

    int errors = 0;
    int checks = 0;

    sbox_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .sbox_in    (sbox_in),
        .sbox_fresh (sbox_fresh),
        .sbox_out   (sbox_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B_90AD_3EF8_4712;
        return tbl[(15 - int'(x)) * 4 +: 4];
    endfunction

    // Masked S-box model: unmask, substitute, re-share with fresh nibbles.
    function automatic logic [OPW-1:0] mask_sbox(input logic [OPW-1:0] op, input logic [FW-1:0] fr);
        logic [3:0] y;
        y = sbox4(op[3:0] ^ op[7:4] ^ op[11:8] ^ op[15:12]);
        return {fr[11:8], fr[7:4], fr[3:0], y ^ fr[3:0] ^ fr[7:4] ^ fr[11:8]};
    endfunction

    function automatic logic [OPW-1:0] make_op(input logic [3:0] x);
        logic [3:0] a, b, c;
        a = 4'($urandom());
        b = 4'($urandom());
        c = 4'($urandom());
        return {c, b, a, x ^ a ^ b ^ c};
    endfunction

    function automatic logic [FW-1:0] rand_fresh();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    // S-box result appears LAT-1 flops after the operand, so it is ready in the last BUSY cycle.
    logic [OPW-1:0] pipe [LAT-1];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mask_sbox(sbox_in, sbox_fresh);
            for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign sbox_out = pipe[LAT-2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        rnd_valid = 1'b0;
        rsp_ready = 1'b0;
        req_data  = '0;
        rnd_data  = '0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '1;
        rnd_valid = 1'b1;
        rsp_ready = 1'b1;
        req_data  = {make_op(4'h3), make_op(4'h9), make_op(4'hC), make_op(4'h1)};
        rnd_data  = rand_fresh();
        repeat (2) step();
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (sbox_in !== '0) begin errors++; $display("FAIL reset_sbox_in: got %h want 0", sbox_in); end
        checks++; if (sbox_fresh !== '0) begin errors++; $display("FAIL reset_sbox_fresh: got %h want 0", sbox_fresh); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        step();
    endtask

    task automatic test_single();
        logic [OPW-1:0] op;
        logic [FW-1:0]  fr;
        logic [3:0]     ux;
        do_reset();
        op = make_op(4'h6);
        fr = rand_fresh();
        req_data[OPW-1:0] = op;
        req_valid = 4'b0001;
        rnd_valid = 1'b1;
        rnd_data  = fr;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        checks++; if (rnd_ready !== 1'b1) begin errors++; $display("FAIL single_rnd_ready: got %b want 1", rnd_ready); end
        step();
        req_valid = '0;
        rnd_valid = 1'b0;
        rnd_data  = rand_fresh();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0 || sbox_in !== op || sbox_fresh !== fr) begin
                errors++;
                $display("FAIL single_busy k=%0d: rsp_valid=%b sbox_in=%h want 0/%h fresh_ok=%b", k, rsp_valid, sbox_in, op, sbox_fresh == fr);
            end
            step();
        end
        @(negedge clk);
        ux = rsp_data[3:0] ^ rsp_data[7:4] ^ rsp_data[11:8] ^ rsp_data[15:12];
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        checks++; if (ux !== 4'hA) begin errors++; $display("FAIL single_unmasked: got %h want a", ux); end
        checks++; if (rsp_data !== mask_sbox(op, fr)) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, mask_sbox(op, fr)); end
        step();
        @(negedge clk);
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", rsp_valid); end
        step();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        do_reset();
        req_data  = {make_op(4'h4), make_op(4'hB), make_op(4'h0), make_op(4'hF)};
        req_valid = 4'b1111;
        rnd_valid = 1'b1;
        rnd_data  = rand_fresh();
        rsp_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            exp = ((c % 10) == 0) ? (4'(1) << ((c / 10) % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp) begin errors++; $display("FAIL contention c=%0d: got %b want %b", c, req_ready, exp); end
            step();
        end
    endtask

    task automatic test_starvation();
        do_reset();
        req_data  = {4{make_op(4'h7)}};
        req_valid = 4'b0010;
        rnd_valid = 1'b0;
        rnd_data  = rand_fresh();
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || rnd_ready !== 1'b0) begin
                errors++; $display("FAIL starve_c%0d: req_ready=%b rnd_ready=%b want 0/0", c, req_ready, rnd_ready);
            end
            step();
        end
        rnd_valid = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL starve_grant: got %b want 0010", req_ready); end
        checks++; if (rnd_ready !== 1'b1) begin errors++; $display("FAIL starve_rnd_ready: got %b want 1", rnd_ready); end
        step();
        req_valid = '0;
        rnd_valid = 1'b0;
        repeat (LAT) step();
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL starve_rsp: got %b want 0010", rsp_valid); end
        step();
    endtask

    task automatic test_backpressure();
        logic [OPW-1:0] op, exp_d;
        logic [FW-1:0]  fr;
        do_reset();
        op = make_op(4'($urandom()));
        fr = rand_fresh();
        req_data  = {make_op(4'h1), make_op(4'h2), make_op(4'h3), op};
        req_valid = 4'b0001;
        rnd_valid = 1'b1;
        rnd_data  = fr;
        rsp_ready = 1'b0;
        exp_d = mask_sbox(op, fr);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
        step();
        req_valid = 4'b1110;
        rnd_data  = rand_fresh();
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_busy_ready c=%0d: got %b want 0", c, req_ready); end
            step();
        end
        for (int c = LAT + 1; c <= LAT + 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== exp_d || req_ready !== '0) begin
                errors++; $display("FAIL bp_hold c=%0d: rsp_valid=%b rsp_data=%h req_ready=%b want 0001/%h/0", c, rsp_valid, rsp_data, req_ready, exp_d);
            end
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0001 || req_ready !== '0) begin errors++; $display("FAIL bp_handshake: rsp_valid=%b req_ready=%b want 0001/0", rsp_valid, req_ready); end
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL bp_released: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
        step();
    endtask

    task automatic test_reset_mid_busy();
        logic [OPW-1:0] op;
        logic [FW-1:0]  fr;
        do_reset();
        req_data  = {make_op(4'h5), make_op(4'h8), make_op(4'hE), make_op(4'h2)};
        req_valid = 4'b0010;
        rnd_valid = 1'b1;
        rnd_data  = rand_fresh();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmb_first_grant: got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rnd_ready !== 1'b0 || rsp_valid !== '0 || sbox_in !== '0 || sbox_fresh !== '0 || rsp_data !== '0) begin
            errors++; $display("FAIL rmb_outputs_zero: req_ready=%b rnd_ready=%b rsp_valid=%b sbox_in=%h rsp_data=%h", req_ready, rnd_ready, rsp_valid, sbox_in, rsp_data);
        end
        step();
        step();
        rst = 1'b1;
        op = req_data[OPW-1:0];
        fr = rand_fresh();
        req_valid = 4'b0101;
        rnd_data  = fr;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmb_ptr_restart: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        rnd_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rmb_no_rsp k=%0d: got %b want 0", k, rsp_valid); end
            step();
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== mask_sbox(op, fr)) begin
            errors++; $display("FAIL rmb_new_rsp: rsp_valid=%b rsp_data=%h want 0001/%h", rsp_valid, rsp_data, mask_sbox(op, fr));
        end
        step();
    endtask

    task automatic test_macro();
        logic [OPW-1:0] op, exp_in;
        logic [FW-1:0]  fr, exp_fr;
        do_reset();
        op = make_op(4'hD);
        fr = rand_fresh();
        req_data  = {op, make_op(4'h0), make_op(4'h0), make_op(4'h0)};
        req_valid = 4'b1000;
        rnd_valid = 1'b1;
        rnd_data  = fr;
        rsp_ready = 1'b1;
`ifdef SBOX_ARB_IDLE_ZERO_EN
        exp_in = '0;
        exp_fr = '0;
`else
        exp_in = op;
        exp_fr = fr;
`endif
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL macro_grant: got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        rnd_valid = 1'b0;
        repeat (LAT) step();
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b1000 || sbox_in !== exp_in) begin errors++; $display("FAIL macro_resp: rsp_valid=%b sbox_in=%h want 1000/%h", rsp_valid, sbox_in, exp_in); end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            checks++;
            if (sbox_in !== exp_in || sbox_fresh !== exp_fr) begin
                errors++; $display("FAIL macro_idle k=%0d: sbox_in=%h want %h fresh_ok=%b", k, sbox_in, exp_in, sbox_fresh == exp_fr);
            end
        end
        step();
    endtask

    task automatic test_random();
        int             m_busy, m_tg, m_g, m_ptr, g, e, idx;
        bit             rel;
        logic [OPW-1:0] m_op, m_last_op, exp_in;
        logic [FW-1:0]  m_fr;
        logic [N-1:0]   exp_rdy;
        do_reset();
        m_busy = 0; m_tg = 0; m_g = 0; m_ptr = 0;
        m_op = '0; m_fr = '0; m_last_op = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*OPW +: OPW] = make_op(4'($urandom()));
                end
            end
            rnd_valid = ($urandom_range(3) != 0);
            rnd_data  = rand_fresh();
            rsp_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            g = -1;
            rel = 1'b0;
            if (m_busy == 0) begin
                if (rnd_valid) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (g < 0 && req_valid[2'(idx)]) g = idx;
                    end
                end
                exp_rdy = (g >= 0) ? (4'(1) << g) : 4'b0000;
`ifdef SBOX_ARB_IDLE_ZERO_EN
                exp_in = '0;
`else
                exp_in = m_last_op;
`endif
                checks++;
                if (req_ready !== exp_rdy || rnd_ready !== (g >= 0) || rsp_valid !== '0 || sbox_in !== exp_in) begin
                    errors++; $display("FAIL rand_idle c=%0d: req_ready=%b rnd_ready=%b rsp_valid=%b sbox_in=%h want %b/%b/0/%h", c, req_ready, rnd_ready, rsp_valid, sbox_in, exp_rdy, g >= 0, exp_in);
                end
                if (g >= 0) begin
                    m_busy = 1; m_tg = c; m_g = g;
                    m_op = req_data[g*OPW +: OPW];
                    m_fr = rnd_data;
                    m_ptr = (g + 1) % N;
                end
            end else begin
                e = c - m_tg;
                if (e <= LAT) begin
                    checks++;
                    if (req_ready !== '0 || rnd_ready !== 1'b0 || rsp_valid !== '0 || sbox_in !== m_op || sbox_fresh !== m_fr) begin
                        errors++; $display("FAIL rand_busy c=%0d: req_ready=%b rsp_valid=%b sbox_in=%h want 0/0/%h", c, req_ready, rsp_valid, sbox_in, m_op);
                    end
                end else begin
                    checks++;
                    if (req_ready !== '0 || rnd_ready !== 1'b0 || rsp_valid !== (4'(1) << m_g) || rsp_data !== mask_sbox(m_op, m_fr)) begin
                        errors++; $display("FAIL rand_resp c=%0d: req_ready=%b rsp_valid=%b rsp_data=%h want 0/%b/%h", c, req_ready, rsp_valid, rsp_data, 4'(1) << m_g, mask_sbox(m_op, m_fr));
                    end
`ifdef SBOX_ARB_IDLE_ZERO_EN
                    checks++;
                    if (sbox_in !== '0) begin errors++; $display("FAIL rand_resp_zero c=%0d: sbox_in=%h want 0", c, sbox_in); end
`endif
                    if (rsp_ready) rel = 1'b1;
                end
            end
            step();
            if (g >= 0) req_valid[2'(g)] = 1'b0;
            if (rel) begin
                m_busy = 0;
                m_last_op = m_op;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_backpressure();
        test_reset_mid_busy();
        test_macro();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
